memory_arbiter: RTL and testbench

Single-port memory arbiter that shares one external memory bus between the fetch stage (instruction reads) and the memory stage (loads/stores). It sequences each bus transaction with a small FSM and applies data-over-fetch priority with a fetch anti-starvation limit. It discards fetch responses cancelled by a PC redirect or trap. It drives the pipeline-wide `stallControl` consumed by the hazard/trap controller whenever a requester is waiting on the bus.

---
 rtl/memory_arbiter.sv | 145 ++++++++++++++
 tb/tb_memory_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and load/store traffic.
// Data has priority over fetch, with a starvation limit so that fetch still gets the bus.
module memory_arbiter #(
  parameter int FETCH_PRIORITY_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchRequest,
  input  logic [31:0] fetchAddress,
  output logic        fetchReady,
  output logic [31:0] fetchData,
  input  logic        dataRequest,
  input  logic        dataWrite,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataWriteData,
  input  logic [3:0]  dataByteEnable,
  output logic        dataReady,
  output logic [31:0] dataReadData,
  input  logic        flush,
  output logic        memoryRequest,
  output logic        memoryWrite,
  output logic [31:0] memoryAddress,
  output logic [31:0] memoryWriteData,
  output logic [3:0]  memoryByteEnable,
  input  logic        memoryAcknowledge,
  input  logic [31:0] memoryReadData,
  output logic        stallControl
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [3:0] LIMIT = 4'(FETCH_PRIORITY_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;

  logic fetch_eligible;
  logic data_wins;

  assign fetch_eligible = fetchRequest && !flush;
  assign data_wins      = dataRequest && (!fetch_eligible || (starve_q < LIMIT));

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;

    case (state_q)
      S_IDLE: begin
        if (!fetchRequest) begin
          starve_d = '0;
        end
        if (data_wins) begin
          state_d     = S_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dataWrite;
          mem_addr_d  = dataAddress;
          mem_wdata_d = dataWriteData;
          mem_be_d    = dataWrite ? dataByteEnable : 4'hF;
          // Count only grants that made a waiting fetch lose; saturate at the limit.
          if (fetchRequest && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (fetch_eligible) begin
          state_d     = S_FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = fetchAddress;
          mem_wdata_d = '0;
          mem_be_d    = 4'hF;
          starve_d    = '0;
        end
      end
      S_FETCH: begin
        if (memoryAcknowledge) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DATA, S_DRAIN: begin
        if (memoryAcknowledge) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign memoryRequest    = mem_req_q;
  assign memoryWrite      = mem_we_q;
  assign memoryAddress    = mem_addr_q;
  assign memoryWriteData  = mem_wdata_q;
  assign memoryByteEnable = mem_be_q;

  // A flush in the acknowledge cycle discards the fetch response.
  assign fetchReady   = reset && (state_q == S_FETCH) && memoryAcknowledge && !flush;
  assign dataReady    = reset && (state_q == S_DATA) && memoryAcknowledge;
  assign fetchData    = memoryReadData;
  assign dataReadData = memoryReadData;

  assign stallControl = reset && ((fetchRequest && !fetchReady && !flush) ||
                                  (dataRequest && !dataReady));

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: loads, stores, contention, flush handling and reset.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_memory_arbiter;

  logic        clock;
  logic        reset;
  logic        fetchRequest;
  logic [31:0] fetchAddress;
  logic        fetchReady;
  logic [31:0] fetchData;
  logic        dataRequest;
  logic        dataWrite;
  logic [31:0] dataAddress;
  logic [31:0] dataWriteData;
  logic [3:0]  dataByteEnable;
  logic        dataReady;
  logic [31:0] dataReadData;
  logic        flush;
  logic        memoryRequest;
  logic        memoryWrite;
  logic [31:0] memoryAddress;
  logic [31:0] memoryWriteData;
  logic [3:0]  memoryByteEnable;
  logic        memoryAcknowledge;
  logic [31:0] memoryReadData;
  logic        stallControl;

  int unsigned total;
  int unsigned bad;
  int unsigned ready_pulses;

  memory_arbiter #(.FETCH_PRIORITY_LIMIT(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .fetchRequest      (fetchRequest),
    .fetchAddress      (fetchAddress),
    .fetchReady        (fetchReady),
    .fetchData         (fetchData),
    .dataRequest       (dataRequest),
    .dataWrite         (dataWrite),
    .dataAddress       (dataAddress),
    .dataWriteData     (dataWriteData),
    .dataByteEnable    (dataByteEnable),
    .dataReady         (dataReady),
    .dataReadData      (dataReadData),
    .flush             (flush),
    .memoryRequest     (memoryRequest),
    .memoryWrite       (memoryWrite),
    .memoryAddress     (memoryAddress),
    .memoryWriteData   (memoryWriteData),
    .memoryByteEnable  (memoryByteEnable),
    .memoryAcknowledge (memoryAcknowledge),
    .memoryReadData    (memoryReadData),
    .stallControl      (stallControl)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    fetchRequest = 1'b1;
    fetchAddress = '0;
    dataRequest = 1'b0;
    dataWrite = 1'b0;
    dataAddress = '0;
    dataWriteData = '0;
    dataByteEnable = '0;
    flush = 1'b0;
    memoryAcknowledge = 1'b0;
    memoryReadData = '0;

    // Reset: outputs quiet even with a fetch request pending.
    tick();
    tick();
    #1;
    check_eq("rst_req", 32'(memoryRequest), 32'd0);
    check_eq("rst_addr", memoryAddress, 32'd0);
    check_eq("rst_be", 32'(memoryByteEnable), 32'd0);
    check_eq("rst_stall", 32'(stallControl), 32'd0);
    check_eq("rst_fready", 32'(fetchReady), 32'd0);
    fetchRequest = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Uncontested load, acknowledge two cycles after memoryRequest.
    ready_pulses = 0;
    dataRequest = 1'b1;
    dataWrite = 1'b0;
    dataAddress = 32'h100;
    dataByteEnable = 4'b0101;
    #1;
    check_eq("ld_stall0", 32'(stallControl), 32'd1);
    tick();
    check_eq("ld_req", 32'(memoryRequest), 32'd1);
    check_eq("ld_addr", memoryAddress, 32'h100);
    check_eq("ld_be", 32'(memoryByteEnable), 32'hF);
    check_eq("ld_we", 32'(memoryWrite), 32'd0);
    check_eq("ld_stall1", 32'(stallControl), 32'd1);
    if (dataReady) ready_pulses++;
    tick();
    check_eq("ld_stall2", 32'(stallControl), 32'd1);
    if (dataReady) ready_pulses++;
    tick();
    memoryAcknowledge = 1'b1;
    memoryReadData = 32'hDEADBEEF;
    #1;
    check_eq("ld_data", dataReadData, 32'hDEADBEEF);
    check_eq("ld_stall3", 32'(stallControl), 32'd0);
    if (dataReady) ready_pulses++;
    tick();
    memoryAcknowledge = 1'b0;
    dataRequest = 1'b0;
    #1;
    if (dataReady) ready_pulses++;
    check_eq("ld_pulses", ready_pulses, 32'd1);
    check_eq("ld_req_off", 32'(memoryRequest), 32'd0);

    // Store with one-cycle acknowledge.
    dataRequest = 1'b1;
    dataWrite = 1'b1;
    dataAddress = 32'h200;
    dataWriteData = 32'h12345678;
    dataByteEnable = 4'b0011;
    tick();
    check_eq("st_req", 32'(memoryRequest), 32'd1);
    check_eq("st_we", 32'(memoryWrite), 32'd1);
    check_eq("st_addr", memoryAddress, 32'h200);
    check_eq("st_wdata", memoryWriteData, 32'h12345678);
    check_eq("st_be", 32'(memoryByteEnable), 32'h3);
    memoryAcknowledge = 1'b1;
    #1;
    check_eq("st_ready", 32'(dataReady), 32'd1);
    tick();
    memoryAcknowledge = 1'b0;
    dataRequest = 1'b0;
    dataWrite = 1'b0;
    check_eq("st_req_off", 32'(memoryRequest), 32'd0);

    // Contention with limit 4: D,D,D,D,F,D,D,D,D,F.
    fetchRequest = 1'b1;
    fetchAddress = 32'h1000;
    dataRequest = 1'b1;
    dataAddress = 32'h2000;
    for (int i = 0; i < 10; i++) begin
      tick();
      memoryAcknowledge = 1'b1;
      memoryReadData = 32'h5000 + 32'(i);
      #1;
      if (i == 4 || i == 9) begin
        check_eq($sformatf("arb%0d_faddr", i), memoryAddress, 32'h1000);
        check_eq($sformatf("arb%0d_fready", i), 32'(fetchReady), 32'd1);
        check_eq($sformatf("arb%0d_dready", i), 32'(dataReady), 32'd0);
      end else begin
        check_eq($sformatf("arb%0d_daddr", i), memoryAddress, 32'h2000);
        check_eq($sformatf("arb%0d_dready", i), 32'(dataReady), 32'd1);
        check_eq($sformatf("arb%0d_fready", i), 32'(fetchReady), 32'd0);
      end
      tick();
      memoryAcknowledge = 1'b0;
    end
    fetchRequest = 1'b0;
    dataRequest = 1'b0;
    tick();

    // Flush one cycle before acknowledge: drain, then the redirected fetch.
    fetchRequest = 1'b1;
    fetchAddress = 32'h40;
    tick();
    check_eq("fl_addr", memoryAddress, 32'h40);
    flush = 1'b1;
    #1;
    check_eq("fl_fready0", 32'(fetchReady), 32'd0);
    tick();
    flush = 1'b0;
    fetchAddress = 32'h80;
    check_eq("dr_req", 32'(memoryRequest), 32'd1);
    check_eq("dr_addr", memoryAddress, 32'h40);
    memoryAcknowledge = 1'b1;
    memoryReadData = 32'h11111111;
    #1;
    check_eq("dr_fready", 32'(fetchReady), 32'd0);
    tick();
    memoryAcknowledge = 1'b0;
    #1;
    check_eq("dr_bubble", 32'(memoryRequest), 32'd0);
    tick();
    check_eq("rf_req", 32'(memoryRequest), 32'd1);
    check_eq("rf_addr", memoryAddress, 32'h80);
    memoryAcknowledge = 1'b1;
    memoryReadData = 32'hCAFEF00D;
    #1;
    check_eq("rf_fready", 32'(fetchReady), 32'd1);
    check_eq("rf_fdata", fetchData, 32'hCAFEF00D);
    tick();
    memoryAcknowledge = 1'b0;
    fetchRequest = 1'b0;

    // Flush coincident with acknowledge in FETCH.
    tick();
    fetchRequest = 1'b1;
    fetchAddress = 32'h44;
    tick();
    flush = 1'b1;
    memoryAcknowledge = 1'b1;
    #1;
    check_eq("fa_fready", 32'(fetchReady), 32'd0);
    tick();
    flush = 1'b0;
    memoryAcknowledge = 1'b0;
    fetchRequest = 1'b0;
    check_eq("fa_idle", 32'(memoryRequest), 32'd0);
    tick();

    // Flush during DATA does not cancel it.
    dataRequest = 1'b1;
    dataWrite = 1'b0;
    dataAddress = 32'h300;
    tick();
    flush = 1'b1;
    tick();
    check_eq("fd_req", 32'(memoryRequest), 32'd1);
    memoryAcknowledge = 1'b1;
    memoryReadData = 32'h0BADF00D;
    #1;
    check_eq("fd_dready", 32'(dataReady), 32'd1);
    tick();
    flush = 1'b0;
    memoryAcknowledge = 1'b0;
    dataRequest = 1'b0;
    check_eq("fd_idle", 32'(memoryRequest), 32'd0);

    // Reset in the middle of a store, then a stray acknowledge.
    dataRequest = 1'b1;
    dataWrite = 1'b1;
    dataAddress = 32'h400;
    dataWriteData = 32'hA5A5A5A5;
    dataByteEnable = 4'hF;
    tick();
    check_eq("rs_req", 32'(memoryRequest), 32'd1);
    reset = 1'b0;
    tick();
    check_eq("rs_req0", 32'(memoryRequest), 32'd0);
    check_eq("rs_we0", 32'(memoryWrite), 32'd0);
    check_eq("rs_addr0", memoryAddress, 32'd0);
    check_eq("rs_wdata0", memoryWriteData, 32'd0);
    check_eq("rs_be0", 32'(memoryByteEnable), 32'd0);
    check_eq("rs_stall0", 32'(stallControl), 32'd0);
    reset = 1'b1;
    dataRequest = 1'b0;
    dataWrite = 1'b0;
    memoryAcknowledge = 1'b1;
    #1;
    check_eq("rs_stray_d", 32'(dataReady), 32'd0);
    check_eq("rs_stray_f", 32'(fetchReady), 32'd0);
    tick();
    memoryAcknowledge = 1'b0;
    check_eq("rs_still_idle", 32'(memoryRequest), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
